multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle RV32I core variant; it sequences a single shared ALU, memory port and register file over several cycles per instruction.
- Decodes `opcode` and drives the mux selects, write enables and the 2-bit ALUOp that feeds the existing ALU decoder. Funct3/funct7 decode stays in the ALU decoder.
- Handshakes with a variable-latency unified memory via `mem_ready`.
- Includes a memory-wait watchdog and a retire pulse for performance counting.

---
 rtl/multicycle_ctrl.sv | 278 +++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM for the multicycle RV32I core. One instruction is
//   sequenced over several cycles through a shared ALU, a unified memory port
//   and the register file. funct3/funct7 decode lives in the ALU decoder; this
//   block only produces the 2-bit ALUOp class for it.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   opcode            instr[6:0] from the instruction register
//   mem_ready         memory completes the pending read/write this cycle
//   branch_taken      branch comparator result (meaningful in BRANCH)
//   pc_write          load PC from the result bus
//   ir_write          latch instruction and old PC
//   adr_src           memory address: 0 = PC, 1 = ALUOut
//   mem_read/write    memory request strobes
//   alu_src_a         00 = PC, 01 = OldPC, 10 = rs1
//   alu_src_b         00 = rs2, 01 = imm, 10 = constant 4
//   alu_op            ALUOp class for the ALU decoder
//   result_src        00 = ALUOut, 01 = memory data, 10 = ALU result
//   reg_write         register file write enable
//   instr_retired     one-cycle pulse when an instruction completes
//   illegal_instr     sticky: unsupported opcode or corrupt state
//   bus_error         sticky: memory wait watchdog expired
//   state_o           current FSM state for debug
//
// Memory handshake: a request (mem_read or mem_write) is held stable, with
// the same address select, in every cycle of a wait state until the memory
// answers with mem_ready=1; the access completes in that same cycle and the
// FSM moves on at the next clock edge. mem_ready is ignored in all other
// states.
// -----------------------------------------------------------------------------

`ifndef ALUOP_LOAD_STORE
`define ALUOP_LOAD_STORE   2'b00
`endif
`ifndef ALUOP_LUI
`define ALUOP_LUI          2'b01
`endif
`ifndef ALUOP_RTYPE_BRANCH
`define ALUOP_RTYPE_BRANCH 2'b10
`endif
`ifndef ALUOP_ITYPE
`define ALUOP_ITYPE        2'b11
`endif

module multicycle_ctrl #(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned CNT_W      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       reg_write,
    output logic       instr_retired,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [1:0] ALUOP_LS    = `ALUOP_LOAD_STORE;
    localparam logic [1:0] ALUOP_LUI_C = `ALUOP_LUI;
    localparam logic [1:0] ALUOP_RB    = `ALUOP_RTYPE_BRANCH;
    localparam logic [1:0] ALUOP_I     = `ALUOP_ITYPE;

    // The watchdog fires on the WAIT_LIMIT-th consecutive stalled cycle, i.e.
    // when the counter already holds WAIT_LIMIT-1 and mem_ready is still low.
    localparam logic [CNT_W-1:0] LIMIT_M1 =
        CNT_W'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic             wait_st;
    logic             expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;
        illegal_d     = illegal_q;
        bus_err_d     = bus_err_q;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        adr_src       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = ALUOP_LS;
        result_src    = 2'b00;
        reg_write     = 1'b0;
        instr_retired = 1'b0;

        wait_st = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                  (state_q == S_MEMWRITE);
        // A mem_ready arriving on the limit cycle wins over the trap.
        expire  = wait_st && !mem_ready && (WAIT_LIMIT != 0) &&
                  (cnt_q == LIMIT_M1);
        if (wait_st && !mem_ready && !expire) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Outputs are held at zero while reset is asserted, even though the
        // state register already reads FETCH.
        if (rst_n) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_read   = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end else if (expire) begin
                        state_d   = S_TRAP;
                        bus_err_d = 1'b1;
                    end
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    case (opcode)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_R:              state_d = S_EXEC_R;
                        OP_I:              state_d = S_EXEC_I;
                        OP_BR:             state_d = S_BRANCH;
                        OP_JAL:            state_d = S_JAL;
                        OP_JALR:           state_d = S_JALR;
                        OP_LUI:            state_d = S_LUI;
                        default: begin
                            state_d   = S_TRAP;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    // opcode[5] separates store (0100011) from load (0000011).
                    state_d   = opcode[5] ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    adr_src  = 1'b1;
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        state_d = S_MEMWB;
                    end else if (expire) begin
                        state_d   = S_TRAP;
                        bus_err_d = 1'b1;
                    end
                end
                S_MEMWB: begin
                    result_src    = 2'b01;
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                    state_d       = S_FETCH;
                end
                S_MEMWRITE: begin
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        instr_retired = 1'b1;
                        state_d       = S_FETCH;
                    end else if (expire) begin
                        state_d   = S_TRAP;
                        bus_err_d = 1'b1;
                    end
                end
                S_EXEC_R: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b00;
                    alu_op    = ALUOP_RB;
                    state_d   = S_ALUWB;
                end
                S_EXEC_I: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_op    = ALUOP_I;
                    state_d   = S_ALUWB;
                end
                S_LUI: begin
                    alu_src_b = 2'b01;
                    alu_op    = ALUOP_LUI_C;
                    state_d   = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                    state_d       = S_FETCH;
                end
                S_BRANCH: begin
                    // Not-taken needs no write: PC already holds PC+4.
                    pc_write      = branch_taken;
                    instr_retired = 1'b1;
                    state_d       = S_FETCH;
                end
                S_JALR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    state_d   = S_JAL;
                end
                S_JAL: begin
                    // PC takes the target from ALUOut while the ALU forms
                    // OldPC+4 for the link write in ALUWB.
                    pc_write  = 1'b1;
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    state_d   = S_ALUWB;
                end
                S_TRAP: begin
                    state_d = S_TRAP;
                end
                default: begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            endcase
        end
    end

    assign illegal_instr = illegal_q;
    assign bus_error     = bus_err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Bench for multicycle_ctrl. A reference model expands each instruction
//   into its per-cycle input stimulus and expected output vector; a driver
//   replays the stimulus and a monitor compares the DUT against the queue.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int W = 21;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [1:0] AOP_LUI = 2'b01;
    localparam logic [1:0] AOP_RB  = 2'b10;
    localparam logic [1:0] AOP_I   = 2'b11;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       irw;
        logic       adr;
        logic       mrd;
        logic       mwr;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] aop;
        logic [1:0] rs;
        logic       rw;
        logic       ret;
        logic       ill;
        logic       berr;
    } out_t;

    typedef struct packed {
        logic [6:0] op;
        logic       rdy;
        logic       bt;
    } stim_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       branch_taken = 1'b0;
    logic       pc_write, ir_write, adr_src, mem_read, mem_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic       reg_write, instr_retired, illegal_instr, bus_error;
    logic [3:0] state_o;

    multicycle_ctrl #(.WAIT_LIMIT(16), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .pc_write(pc_write), .ir_write(ir_write),
        .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .reg_write(reg_write),
        .instr_retired(instr_retired), .illegal_instr(illegal_instr),
        .bus_error(bus_error), .state_o(state_o)
    );

    // scoreboard
    logic [W-1:0] exp_q[$];
    stim_t        stim_q[$];
    logic         drv_active = 1'b0;
    int           n_cmp = 0;
    int           n_err = 0;

    function automatic out_t dut_out();
        out_t a;
        a.st = state_o; a.pcw = pc_write; a.irw = ir_write; a.adr = adr_src;
        a.mrd = mem_read; a.mwr = mem_write; a.sa = alu_src_a;
        a.sb = alu_src_b; a.aop = alu_op; a.rs = result_src; a.rw = reg_write;
        a.ret = instr_retired; a.ill = illegal_instr; a.berr = bus_error;
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp,
                     $time);
        end
    endtask

    // reference model
    function automatic out_t st(input int s);
        out_t o;
        o = '0;
        o.st = 4'(s);
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [6:0] op, input logic rdy,
                        input logic bt, input out_t e);
        stim_t s;
        s.op = op; s.rdy = rdy; s.bt = bt;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic mdl_fetch(input logic [6:0] op, input int zeros);
        out_t e;
        e = st(0); e.mrd = 1'b1; e.sb = 2'b10; e.rs = 2'b10;
        for (int i = 0; i < zeros; i++) push(op, 1'b0, rb(), e);
        e.irw = 1'b1; e.pcw = 1'b1;
        push(op, 1'b1, rb(), e);
    endtask

    task automatic mdl_decode(input logic [6:0] op);
        out_t e;
        e = st(1); e.sa = 2'b01; e.sb = 2'b01;
        push(op, rb(), rb(), e);
    endtask

    task automatic mdl_memadr(input logic [6:0] op);
        out_t e;
        e = st(2); e.sa = 2'b10; e.sb = 2'b01;
        push(op, rb(), rb(), e);
    endtask

    task automatic mdl_aluwb(input logic [6:0] op);
        out_t e;
        e = st(8); e.rw = 1'b1; e.ret = 1'b1;
        push(op, rb(), rb(), e);
    endtask

    task automatic mdl_jal(input logic [6:0] op);
        out_t e;
        e = st(10); e.pcw = 1'b1; e.sa = 2'b01; e.sb = 2'b10;
        push(op, rb(), rb(), e);
    endtask

    task automatic mdl_trap(input logic [6:0] op, input int n,
                            input logic ill, input logic berr);
        out_t e;
        e = st(15); e.ill = ill; e.berr = berr;
        for (int i = 0; i < n; i++) push(op, rb(), rb(), e);
    endtask

    // One complete legal instruction: fz stalled fetch cycles, mz stalled
    // data-memory cycles, bt branch outcome.
    task automatic mdl_instr(input logic [6:0] op, input logic bt,
                             input int fz, input int mz);
        out_t e;
        mdl_fetch(op, fz);
        mdl_decode(op);
        case (op)
            OP_LOAD: begin
                mdl_memadr(op);
                e = st(3); e.adr = 1'b1; e.mrd = 1'b1;
                for (int i = 0; i < mz; i++) push(op, 1'b0, rb(), e);
                push(op, 1'b1, rb(), e);
                e = st(4); e.rs = 2'b01; e.rw = 1'b1; e.ret = 1'b1;
                push(op, rb(), rb(), e);
            end
            OP_STORE: begin
                mdl_memadr(op);
                e = st(5); e.adr = 1'b1; e.mwr = 1'b1;
                for (int i = 0; i < mz; i++) push(op, 1'b0, rb(), e);
                e.ret = 1'b1;
                push(op, 1'b1, rb(), e);
            end
            OP_R: begin
                e = st(6); e.sa = 2'b10; e.aop = AOP_RB;
                push(op, rb(), rb(), e);
                mdl_aluwb(op);
            end
            OP_I: begin
                e = st(7); e.sa = 2'b10; e.sb = 2'b01; e.aop = AOP_I;
                push(op, rb(), rb(), e);
                mdl_aluwb(op);
            end
            OP_LUI: begin
                e = st(12); e.sb = 2'b01; e.aop = AOP_LUI;
                push(op, rb(), rb(), e);
                mdl_aluwb(op);
            end
            OP_BR: begin
                e = st(9); e.pcw = bt; e.ret = 1'b1;
                push(op, rb(), bt, e);
            end
            OP_JALR: begin
                e = st(11); e.sa = 2'b10; e.sb = 2'b01;
                push(op, rb(), rb(), e);
                mdl_jal(op);
                mdl_aluwb(op);
            end
            default: begin // OP_JAL
                mdl_jal(op);
                mdl_aluwb(op);
            end
        endcase
    endtask

    // driver: releases reset on a falling edge and replays one cycle of
    // stimulus per falling edge
    task automatic run_episode();
        stim_t s;
        @(negedge clk);
        rst_n = 1'b1;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            opcode = s.op; mem_ready = s.rdy; branch_taken = s.bt;
            drv_active = 1'b1;
            @(negedge clk);
        end
        drv_active = 1'b0;
    endtask

    task automatic end_episode(input string tag);
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        #1 rst_n = 1'b0;
        #1 check({tag, "_rst_async"}, 32'(dut_out()), 32'd0);
        repeat (2) @(negedge clk);
        #2 check({tag, "_rst_hold"}, 32'(dut_out()), 32'd0);
    endtask

    // monitor
    initial begin
        out_t e;
        forever begin
            @(negedge clk);
            #2;
            if (drv_active) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL cycle_unexpected: got %h, expected none",
                             dut_out());
                end else begin
                    e = out_t'(exp_q.pop_front());
                    check("cycle", 32'(dut_out()), 32'(e));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: run exceeded time limit");
        $fatal(1, "timeout");
    end

    logic [6:0] legal_ops [9];
    logic [6:0] op;

    initial begin
        legal_ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR,
                      OP_LUI, OP_R};

        // power-on reset
        repeat (3) @(negedge clk);
        #2 check("por_outputs", 32'(dut_out()), 32'd0);

        // directed program
        mdl_instr(OP_R,     1'b0, 0, 0);
        mdl_instr(OP_LOAD,  1'b0, 0, 3);
        mdl_instr(OP_STORE, 1'b0, 0, 1);
        mdl_instr(OP_BR,    1'b0, 0, 0);
        mdl_instr(OP_BR,    1'b1, 0, 0);
        mdl_instr(OP_JALR,  1'b0, 0, 0);
        mdl_instr(OP_JAL,   1'b0, 0, 0);
        mdl_instr(OP_LUI,   1'b0, 0, 0);
        mdl_instr(OP_I,     1'b0, 0, 0);
        mdl_instr(OP_R,     1'b0, 15, 0);  // ready on exactly the 16th cycle
        mdl_instr(OP_LOAD,  1'b0, 0, 15);
        mdl_instr(OP_STORE, 1'b0, 0, 15);
        run_episode();
        end_episode("directed");

        // random program
        for (int i = 0; i < 60; i++) begin
            op = legal_ops[$urandom_range(0, 8)];
            mdl_instr(op, rb(),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15)
                                                  : $urandom_range(0, 2),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15)
                                                  : $urandom_range(0, 2));
        end
        run_episode();
        end_episode("random");

        // illegal opcode 0000000, then a random illegal one
        mdl_instr(OP_I, 1'b0, 0, 0);
        mdl_fetch(7'b0000000, 0);
        mdl_decode(7'b0000000);
        mdl_trap(7'b0000000, 20, 1'b1, 1'b0);
        run_episode();
        end_episode("illegal0");

        do op = 7'($urandom_range(0, 127));
        while (op inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL,
                          OP_JALR, OP_LUI});
        mdl_fetch(op, 2);
        mdl_decode(op);
        mdl_trap(op, 6, 1'b1, 1'b0);
        run_episode();
        end_episode("illegal_rnd");

        // fetch watchdog: 16 stalled cycles trap
        mdl_instr(OP_R, 1'b0, 0, 0);
        begin
            out_t e;
            e = st(0); e.mrd = 1'b1; e.sb = 2'b10; e.rs = 2'b10;
            for (int i = 0; i < 16; i++) push(OP_R, 1'b0, rb(), e);
        end
        mdl_trap(OP_R, 8, 1'b0, 1'b1);
        run_episode();
        end_episode("bus_fetch");

        // load watchdog in MEMREAD
        mdl_fetch(OP_LOAD, 1);
        mdl_decode(OP_LOAD);
        mdl_memadr(OP_LOAD);
        begin
            out_t e;
            e = st(3); e.adr = 1'b1; e.mrd = 1'b1;
            for (int i = 0; i < 16; i++) push(OP_LOAD, 1'b0, rb(), e);
        end
        mdl_trap(OP_LOAD, 4, 1'b0, 1'b1);
        run_episode();
        end_episode("bus_memread");

        // reset asserted in the middle of a stalled load
        mdl_fetch(OP_LOAD, 0);
        mdl_decode(OP_LOAD);
        mdl_memadr(OP_LOAD);
        begin
            out_t e;
            e = st(3); e.adr = 1'b1; e.mrd = 1'b1;
            for (int i = 0; i < 2; i++) push(OP_LOAD, 1'b0, rb(), e);
        end
        run_episode();
        #1;
        check("mid_memread_state", 32'(state_o), 32'd3);
        check("mid_memread_req", 32'({mem_read, adr_src}), 32'b11);
        end_episode("mid_memread");

        // recovery after reset: a normal instruction runs again
        mdl_instr(OP_LOAD, 1'b0, 1, 2);
        run_episode();
        end_episode("recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
